// File: rtl/alu_acc_ctrl.sv
// Accumulator controller around an external 4-bit ALU: valid/ready command in,
// valid/ready response out, with a 4-cycle shift-and-add multiply through ALU ADD passes.
module alu_acc_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_err,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic [3:0] acc_out
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid and its payload are held unchanged until that edge.

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_CLR  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_q;
    logic [3:0] opnd_q;
    logic [3:0] acc;
    logic [3:0] p;
    logic [1:0] idx;
    logic       sticky;
    logic       carry_q;
    logic       zero_q;
    logic       err_q;

    logic [3:0] acc_nxt;
    logic       carry_nxt;
    logic       zero_nxt;
    logic       err_nxt;

    logic [7:0] m_shift;
    logic       take;
    logic [3:0] p_nxt;
    logic       sticky_nxt;

    // Multiplicand is the accumulator itself; it cannot change while MUL runs.
    assign m_shift    = {4'b0000, acc} << idx;
    assign take       = opnd_q[idx];
    assign p_nxt      = take ? alu_result : p;
    assign sticky_nxt = sticky | (take & (alu_carry | (|m_shift[7:4])));

    assign cmd_ready = (state == IDLE) & ~rst;
    assign rsp_valid = (state == RESP);
    assign rsp_data  = acc;
    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;
    assign rsp_err   = err_q;
    assign acc_out   = acc;

    always_comb begin
        acc_nxt   = acc;
        carry_nxt = 1'b0;
        zero_nxt  = (acc == 4'd0);
        err_nxt   = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                acc_nxt   = alu_result;
                carry_nxt = alu_carry;
                zero_nxt  = alu_zero;
            end
            OP_LOAD: begin
                acc_nxt  = opnd_q;
                zero_nxt = (opnd_q == 4'd0);
            end
            OP_CLR: begin
                acc_nxt  = 4'd0;
                zero_nxt = 1'b1;
            end
            default: err_nxt = (op_q == OP_ILL);
        endcase
    end

    always_comb begin
        state_nxt = state;
        alu_a     = acc;
        alu_b     = opnd_q;
        alu_sel   = 2'b00;
        case (state)
            IDLE: begin
                if (cmd_valid) state_nxt = (cmd_op == OP_MUL) ? MUL : EXEC;
            end
            EXEC: begin
                case (op_q)
                    OP_SUB:  alu_sel = 2'b01;
                    OP_AND:  alu_sel = 2'b10;
                    OP_OR:   alu_sel = 2'b11;
                    default: alu_sel = 2'b00;
                endcase
                state_nxt = RESP;
            end
            MUL: begin
                alu_a = p;
                alu_b = m_shift[3:0];
                if (idx == 2'd3) state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 3'd0;
            opnd_q  <= 4'd0;
            acc     <= 4'd0;
            p       <= 4'd0;
            idx     <= 2'd0;
            sticky  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= cmd_op;
                        opnd_q <= cmd_data;
                        p      <= 4'd0;
                        idx    <= 2'd0;
                        sticky <= 1'b0;
                    end
                end
                EXEC: begin
                    acc     <= acc_nxt;
                    carry_q <= carry_nxt;
                    zero_q  <= zero_nxt;
                    err_q   <= err_nxt;
                end
                MUL: begin
                    p      <= p_nxt;
                    sticky <= sticky_nxt;
                    idx    <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        acc     <= p_nxt;
                        carry_q <= sticky_nxt;
                        zero_q  <= (p_nxt == 4'd0);
                        err_q   <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
